// File: rtl/leaf_bridge_pkg.sv
// rtl/leaf_bridge_pkg.sv - shared types and helpers for the leaf user bridge
package leaf_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HALT  = 2'd2
  } bridge_state_t;

  localparam int RUN_COUNT_BITS = 16;

  // Bit offset of channel ch inside a packed multi-channel bus.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/leaf_bridge_fifo.sv
// rtl/leaf_bridge_fifo.sv - synchronous first-word-fall-through FIFO with registered head
module leaf_bridge_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [WIDTH-1:0]    head;
  logic                full, empty, push, pop;

  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Full blocks a push even if a pop frees a slot in the same cycle.
  assign push = in_tvalid & ~full;
  assign pop  = out_tvalid & out_tready;

  assign wr_ptr_nxt = wr_ptr + {{DEPTH_LOG2{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop};

  assign in_tready  = ~full;
  assign out_tvalid = ~empty;
  assign out_tdata  = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_tdata;
    end
  end

  // Head register tracks the slot rd_ptr will point at; a word landing in an
  // empty FIFO is forwarded straight from the input. When empty it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (rd_ptr_nxt != wr_ptr_nxt) begin
        if (push && (rd_ptr_nxt == wr_ptr)) begin
          head <= in_tdata;
        end else begin
          head <= mem[rd_ptr_nxt[DEPTH_LOG2-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/leaf_user_bridge.sv
// rtl/leaf_user_bridge.sv - leaf interface to HLS kernel stream bridge with ap_ctrl_hs sequencer
module leaf_user_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN          = 2,
  parameter int NUM_OUT         = 2,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter bit AUTO_RESTART    = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            kernel_en,
  input  logic [NUM_IN*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [NUM_IN-1:0]               vld_interface2user,
  output logic [NUM_IN-1:0]               ack_user2interface,
  output logic [NUM_IN*PAYLOAD_BITS-1:0]  Input_V_TDATA,
  output logic [NUM_IN-1:0]               Input_V_TVALID,
  input  logic [NUM_IN-1:0]               Input_V_TREADY,
  input  logic [NUM_OUT*PAYLOAD_BITS-1:0] Output_V_TDATA,
  input  logic [NUM_OUT-1:0]              Output_V_TVALID,
  output logic [NUM_OUT-1:0]              Output_V_TREADY,
  output logic [NUM_OUT*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT-1:0]              vld_user2interface,
  input  logic [NUM_OUT-1:0]              ack_interface2user,
  output logic                            ap_rst_n,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_idle,
  output logic [RUN_COUNT_BITS-1:0]       run_count
);

  bridge_state_t state, state_nxt;
  logic          count_inc;
  logic          idle_unused;

  assign ap_rst_n    = ~reset;
  assign idle_unused = ap_idle;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    localparam int unsigned LSB = chan_lsb(i, PAYLOAD_BITS);
    leaf_bridge_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .in_tdata   (dout_leaf_interface2user[LSB +: PAYLOAD_BITS]),
      .in_tvalid  (vld_interface2user[i]),
      .in_tready  (ack_user2interface[i]),
      .out_tdata  (Input_V_TDATA[LSB +: PAYLOAD_BITS]),
      .out_tvalid (Input_V_TVALID[i]),
      .out_tready (Input_V_TREADY[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    localparam int unsigned LSB = chan_lsb(j, PAYLOAD_BITS);
    leaf_bridge_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .in_tdata   (Output_V_TDATA[LSB +: PAYLOAD_BITS]),
      .in_tvalid  (Output_V_TVALID[j]),
      .in_tready  (Output_V_TREADY[j]),
      .out_tdata  (din_leaf_user2interface[LSB +: PAYLOAD_BITS]),
      .out_tvalid (vld_user2interface[j]),
      .out_tready (ack_interface2user[j])
    );
  end

  // A run in progress is never aborted: kernel_en is only honoured on ap_done.
  always_comb begin
    state_nxt = state;
    count_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (kernel_en) state_nxt = ST_START;
      end
      ST_START: begin
        if (ap_done) begin
          count_inc = 1'b1;
          if (!kernel_en)         state_nxt = ST_IDLE;
          else if (!AUTO_RESTART) state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!kernel_en) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      run_count <= '0;
    end else begin
      state <= state_nxt;
      if (count_inc) run_count <= run_count + RUN_COUNT_BITS'(1);
    end
  end

  assign ap_start = (state == ST_START);

endmodule

// File: tb/tb_leaf_user_bridge.sv
// tb/tb_leaf_user_bridge.sv - directed self-checking bench for leaf_user_bridge
module tb_leaf_user_bridge;

  logic        clk = 1'b0;
  logic        reset, kernel_en, ap_done, ap_idle;
  logic [63:0] dout_i, otdata;
  logic [1:0]  vld_i, tready_i, otvalid, ack_i;

  logic [1:0]  ack_a, itvalid_a, otready_a, vldo_a;
  logic [63:0] itdata_a, din_a;
  logic        rst_n_a, start_a;
  logic [15:0] count_a;

  logic [1:0]  ack_b, itvalid_b, otready_b, vldo_b;
  logic [63:0] itdata_b, din_b;
  logic        rst_n_b, start_b;
  logic [15:0] count_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  leaf_user_bridge #(.AUTO_RESTART(1'b1)) u_dut (
    .clk(clk), .reset(reset), .kernel_en(kernel_en),
    .dout_leaf_interface2user(dout_i), .vld_interface2user(vld_i),
    .ack_user2interface(ack_a), .Input_V_TDATA(itdata_a),
    .Input_V_TVALID(itvalid_a), .Input_V_TREADY(tready_i),
    .Output_V_TDATA(otdata), .Output_V_TVALID(otvalid),
    .Output_V_TREADY(otready_a), .din_leaf_user2interface(din_a),
    .vld_user2interface(vldo_a), .ack_interface2user(ack_i),
    .ap_rst_n(rst_n_a), .ap_start(start_a), .ap_done(ap_done),
    .ap_idle(ap_idle), .run_count(count_a)
  );

  leaf_user_bridge #(.AUTO_RESTART(1'b0)) u_dut_once (
    .clk(clk), .reset(reset), .kernel_en(kernel_en),
    .dout_leaf_interface2user(dout_i), .vld_interface2user(vld_i),
    .ack_user2interface(ack_b), .Input_V_TDATA(itdata_b),
    .Input_V_TVALID(itvalid_b), .Input_V_TREADY(tready_i),
    .Output_V_TDATA(otdata), .Output_V_TVALID(otvalid),
    .Output_V_TREADY(otready_b), .din_leaf_user2interface(din_b),
    .vld_user2interface(vldo_b), .ack_interface2user(ack_i),
    .ap_rst_n(rst_n_b), .ap_start(start_b), .ap_done(ap_done),
    .ap_idle(ap_idle), .run_count(count_b)
  );

  typedef struct {
    logic        en;
    logic        done;
    logic        exp_start_a;
    logic [15:0] exp_cnt_a;
    logic        exp_start_b;
    logic [15:0] exp_cnt_b;
  } fsm_vec_t;

  fsm_vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int acc;
    int got;

    // {kernel_en, ap_done} -> ap_start/run_count after the edge, restart DUT then run-once DUT
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 16'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'd4, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'd4, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 16'd2};

    reset = 1'b1; kernel_en = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    dout_i = '0; vld_i = '0; tready_i = '0; otdata = '0; otvalid = '0; ack_i = '0;
    step(); step();
    check("rst_ap_rst_n", rst_n_a, 1'b0);
    check("rst_ap_start", start_a, 1'b0);
    check("rst_run_count", count_a, 16'd0);
    check("rst_in_valid", itvalid_a, 2'b00);
    check("rst_out_valid", vldo_a, 2'b00);
    check("rst_ack", ack_a, 2'b11);
    check("rst_tready", otready_a, 2'b11);
    reset = 1'b0;
    step();
    check("ap_rst_n_released", rst_n_a, 1'b1);
    check("idle_ack", ack_a, 2'b11);

    for (int v = 0; v < 11; v++) begin
      kernel_en = vecs[v].en;
      ap_done   = vecs[v].done;
      step();
      check($sformatf("fsm%0d_start_auto", v), start_a, vecs[v].exp_start_a);
      check($sformatf("fsm%0d_count_auto", v), count_a, vecs[v].exp_cnt_a);
      check($sformatf("fsm%0d_start_once", v), start_b, vecs[v].exp_start_b);
      check($sformatf("fsm%0d_count_once", v), count_b, vecs[v].exp_cnt_b);
    end
    kernel_en = 1'b0; ap_done = 1'b0;

    // Single word latency on input channel 0
    tready_i[0] = 1'b1;
    dout_i[31:0] = 32'hDEADBEEF; vld_i[0] = 1'b1;
    step();
    vld_i[0] = 1'b0;
    check("single_valid", itvalid_a[0], 1'b1);
    check("single_data", itdata_a[31:0], 32'hDEADBEEF);
    step();
    check("single_valid_gone", itvalid_a[0], 1'b0);
    check("single_data_held", itdata_a[31:0], 32'hDEADBEEF);

    // Fill channel 1 with the kernel stalled
    tready_i[1] = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      dout_i[63:32] = 32'hA000_0000 + acc;
      vld_i[1] = 1'b1;
      if (ack_a[1]) acc++;
      step();
    end
    vld_i[1] = 1'b0;
    check("full_ack_count", acc, 16);
    check("full_ack_low", ack_a[1], 1'b0);
    check("full_head", itdata_a[63:32], 32'hA000_0000);
    tready_i[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (itvalid_a[1]) begin
        check($sformatf("full_word%0d", got), itdata_a[63:32], 32'hA000_0000 + got);
        got++;
      end
      step();
    end
    check("full_drain_count", got, 16);
    check("full_drained_valid", itvalid_a[1], 1'b0);
    check("full_ack_back", ack_a[1], 1'b1);
    check("full_data_held", itdata_a[63:32], 32'hA000_000F);

    // Output channel 0: level 5, then 100 cycles of simultaneous push and pop
    ack_i[0] = 1'b0; otvalid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      otdata[31:0] = 32'h1000 + k;
      step();
    end
    ack_i[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      otdata[31:0] = 32'h1000 + 5 + k;
      check($sformatf("pp_valid%0d", k), vldo_a[0], 1'b1);
      check($sformatf("pp_data%0d", k), din_a[31:0], 32'h1000 + k);
      step();
    end
    otvalid[0] = 1'b0;
    check("pp_ready", otready_a[0], 1'b1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("pp_tail_valid%0d", k), vldo_a[0], 1'b1);
      check($sformatf("pp_tail_data%0d", k), din_a[31:0], 32'h1000 + 100 + k);
      step();
    end
    check("pp_empty", vldo_a[0], 1'b0);
    ack_i[0] = 1'b0;

    // Reset with 8 words buffered on input channel 0
    tready_i[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      dout_i[31:0] = 32'hB000 + k; vld_i[0] = 1'b1;
      step();
    end
    vld_i[0] = 1'b0;
    check("pre_reset_valid", itvalid_a[0], 1'b1);
    check("pre_reset_count", count_a, 16'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_in_valid", itvalid_a, 2'b00);
    check("mid_reset_out_valid", vldo_a, 2'b00);
    check("mid_reset_count", count_a, 16'd0);
    check("mid_reset_start", start_a, 1'b0);
    check("mid_reset_ack", ack_a, 2'b11);
    dout_i[31:0] = 32'h1; vld_i[0] = 1'b1; tready_i[0] = 1'b1;
    step();
    vld_i[0] = 1'b0;
    check("post_reset_valid", itvalid_a[0], 1'b1);
    check("post_reset_data", itdata_a[31:0], 32'h1);
    step();
    check("post_reset_no_stale", itvalid_a[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/leaf_user_bridge.md
Name: leaf_user_bridge

Overview:
- Parametrised bridge between the user side of a leaf's leaf_interface instances and an HLS kernel's AXI-stream ports.
- Generalises the single fixed kernel hookup to NUM_IN/NUM_OUT channels.
- Adds a per-channel elastic FIFO and an ap_ctrl_hs start/restart state machine with a run counter.
- Sits inside each page's leaf_N wrapper, between the leaf_interface instances and the user kernel.

Parameters:
- PAYLOAD_BITS, 32, width of one stream word.
- NUM_IN, 2, number of interface-to-kernel channels (1..8).
- NUM_OUT, 2, number of kernel-to-interface channels (1..8).
- FIFO_DEPTH_LOG2, 4, log2 of per-channel FIFO depth (depth 16).
- AUTO_RESTART, 1, 1 = re-issue ap_start after every ap_done; 0 = run once, then halt.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- kernel_en  in  1  permits kernel start.
- dout_leaf_interface2user  in  NUM_IN*PAYLOAD_BITS  packed words from the interface; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_interface2user  in  NUM_IN  word valid per channel.
- ack_user2interface  out  NUM_IN  word accepted per channel.
- Input_V_TDATA  out  NUM_IN*PAYLOAD_BITS  to kernel.
- Input_V_TVALID  out  NUM_IN  to kernel.
- Input_V_TREADY  in  NUM_IN  from kernel.
- Output_V_TDATA  in  NUM_OUT*PAYLOAD_BITS  from kernel.
- Output_V_TVALID  in  NUM_OUT  from kernel.
- Output_V_TREADY  out  NUM_OUT  to kernel.
- din_leaf_user2interface  out  NUM_OUT*PAYLOAD_BITS  to interface.
- vld_user2interface  out  NUM_OUT  to interface.
- ack_interface2user  in  NUM_OUT  from interface.
- ap_rst_n  out  1  kernel reset, equal to ~reset (combinational).
- ap_start  out  1  kernel start.
- ap_done  in  1  kernel done pulse.
- ap_idle  in  1  kernel idle (status only).
- run_count  out  16  completed kernel runs.

Behaviour:
- Transfer rule: a transfer occurs on any valid/ack or TVALID/TREADY pair high in the same cycle. Every FIFO port uses this rule.
- Channels: one FIFO per channel, depth 2^FIFO_DEPTH_LOG2.
  - Input path: interface → FIFO → kernel.
  - Output path: kernel → FIFO → interface.
- Push side:
  - ack_user2interface[i] = ~full[i].
  - Output_V_TREADY[j] = ~full[j].
  - Full blocks push even when a pop happens in the same cycle. No bypass.
- Pop side:
  - First-word-fall-through with a registered head.
  - A word pushed at cycle t is presented at t+1 (TVALID / vld_user2interface high).
  - Empty → valid low; data holds its last value.
- Simultaneous push and pop when neither full nor empty: level unchanged, order preserved.
- Pointers are FIFO_DEPTH_LOG2+1 bits; they wrap modulo 2^(FIFO_DEPTH_LOG2+1). full/empty come from MSB-differ / equal pointers.
- Reset values:
  - All FIFOs empty.
  - All valid outputs 0.
  - All ack/TREADY outputs 1, since the FIFOs are not full; this is the same value as the first cycle after reset.
  - ap_start 0, run_count 0, FSM in IDLE.
- Reset mid-operation: FIFO contents discarded, FSM to IDLE next edge, no partial word emitted.
- FSM states IDLE, START, HALT:
  - IDLE: ap_start=0. Moves to START on the cycle after kernel_en=1.
  - START: ap_start=1.
    - On ap_done=1: run_count += 1 (wraps 0xFFFF→0).
    - If AUTO_RESTART=1, stay in START with ap_start held high.
    - If AUTO_RESTART=0, go to HALT.
    - kernel_en=0 while ap_done=0: stay in START. A run is never aborted.
    - kernel_en=0 together with ap_done: go to IDLE after counting.
  - HALT: ap_start=0. Moves to IDLE when kernel_en=0.
- ap_done outside START is ignored (not counted).
- Data flow is independent of FSM state; FIFOs run in every state.

Decomposition:
- Package leaf_bridge_pkg:
  - FSM state enum (IDLE/START/HALT).
  - RUN_COUNT_BITS=16.
  - Channel-slice helper function.
- Sub-module leaf_bridge_fifo: parameters WIDTH and DEPTH_LOG2; a sync FWFT FIFO with valid/ready on both sides.
- Top instantiates NUM_IN + NUM_OUT copies through generate loops, plus the FSM.

Test Plan:
- Single word: defaults; push 0xDEADBEEF on input channel 0 at cycle 10 with TREADY=1 → Input_V_TVALID[0]=1 with TDATA 0xDEADBEEF at cycle 11, for exactly one cycle.
- Full: hold TREADY[1]=0, offer 20 words on channel 1 → exactly 16 acks, then ack=0. Raise TREADY → 16 words out in order, then ack=1 again.
- Simultaneous push and pop: at level 5, push and pop for 100 cycles → level stays 5 and all 100 words arrive in order across the wrap.
- FSM with AUTO_RESTART=1:
  - kernel_en=1 at cycle 3 → ap_start=1 at cycle 4.
  - Three ap_done pulses → run_count=3, ap_start stays 1.
  - kernel_en=0 with a 4th ap_done → IDLE, run_count=4.
- FSM with AUTO_RESTART=0: one ap_done → HALT with ap_start=0. A stray ap_done leaves run_count=1. kernel_en low → IDLE.
- Reset mid-stream: 8 words buffered, reset for 1 cycle → all valids 0 and run_count 0 the next cycle. A new word 0x1 is delivered first, with no stale data.
